// File: rtl/plane_inlier_counter.sv
// Fixed-point types, a multi-cycle dot product, and the RANSAC inlier counter that
// scores one plane hypothesis against a stream of points.

package ransac_fixed;
  localparam int unsigned value_width = 32;
  localparam int unsigned frac_bits = 16;

  function automatic int unsigned value_bits();
    return value_width;
  endfunction

  typedef logic signed [value_width-1:0] fixed_t;

  localparam fixed_t fixed_max = {1'b0, {(value_width-1){1'b1}}};
  localparam fixed_t fixed_min = {1'b1, {(value_width-1){1'b0}}};

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } point_t;

  typedef struct packed {
    point_t normal;
    fixed_t d;
  } plane_t;
endpackage

// Three-term fixed-point dot product; result saturates, valid follows input_valid by latency cycles.
module slow_vector_dot_product #(
  parameter int unsigned latency = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  ransac_fixed::point_t  lhs,
  input  ransac_fixed::point_t  rhs,
  input  logic                  input_valid,
  output ransac_fixed::fixed_t  result,
  output logic                  output_valid
);
  localparam int unsigned vw = ransac_fixed::value_bits();
  localparam int unsigned pw = 2 * vw;
  localparam int unsigned sw = pw + 2;

  logic signed [pw-1:0] px, py, pz;
  logic signed [sw-1:0] sum_c, shifted_c;
  ransac_fixed::fixed_t result_c;
  logic [latency*vw-1:0] pipe_q;
  logic [latency-1:0] vld_q;

  always_comb begin
    px = pw'(lhs.x) * pw'(rhs.x);
    py = pw'(lhs.y) * pw'(rhs.y);
    pz = pw'(lhs.z) * pw'(rhs.z);
    sum_c = sw'(px) + sw'(py) + sw'(pz);
    shifted_c = sum_c >>> ransac_fixed::frac_bits;
    if (shifted_c > sw'(ransac_fixed::fixed_max)) begin
      result_c = ransac_fixed::fixed_max;
    end else if (shifted_c < sw'(ransac_fixed::fixed_min)) begin
      result_c = ransac_fixed::fixed_min;
    end else begin
      result_c = shifted_c[vw-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q  <= '0;
      pipe_q <= '0;
    end else begin
      vld_q  <= latency'({vld_q, input_valid});
      pipe_q <= (latency*vw)'({pipe_q, result_c});
    end
  end

  assign result       = pipe_q[latency*vw-1 -: vw];
  assign output_valid = vld_q[latency-1];
endmodule

module plane_inlier_counter #(
  parameter int unsigned multiply_latency = ransac_fixed::value_bits() / 16,
  parameter int unsigned count_bits       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  ransac_fixed::plane_t  plane,
  input  ransac_fixed::fixed_t  threshold,
  input  logic [count_bits-1:0] num_points,
  input  logic                  plane_valid,
  output logic                  plane_ready,
  input  ransac_fixed::point_t  point,
  input  logic                  point_valid,
  output logic                  point_ready,
  output logic                  point_result_valid,
  output logic                  point_is_inlier,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [count_bits-1:0] inlier_count
);
  localparam int unsigned value_width = ransac_fixed::value_bits();

  typedef enum logic [2:0] {IDLE, ACCEPT, DOT_WAIT, COMPARE, DONE} state_t;

  state_t state, state_d;
  ransac_fixed::plane_t plane_q, plane_d;
  ransac_fixed::fixed_t threshold_q, threshold_d, dot_q, dot_d, dot_result, dist_c;
  ransac_fixed::point_t dot_rhs_q, dot_rhs_d;
  logic [count_bits-1:0] num_points_q, num_points_d, processed_q, processed_d, inlier_count_d;
  logic plane_ready_d, point_ready_d, point_result_valid_d, point_is_inlier_d, output_valid_d;
  logic dot_start_q, dot_start_d, dot_valid, inlier_c;
  logic signed [value_width:0] diff_c, mag_c;

  slow_vector_dot_product #(.latency(multiply_latency)) u_dot (
    .clock        (clock),
    .reset        (reset),
    .lhs          (plane_q.normal),
    .rhs          (dot_rhs_q),
    .input_valid  (dot_start_q),
    .result       (dot_result),
    .output_valid (dot_valid)
  );

  // One extra bit keeps dot - d from wrapping; magnitude saturates back into fixed_t.
  always_comb begin
    diff_c = (value_width+1)'(dot_q) - (value_width+1)'(plane_q.d);
    mag_c  = diff_c[value_width] ? -diff_c : diff_c;
    if (mag_c > (value_width+1)'(ransac_fixed::fixed_max)) begin
      dist_c = ransac_fixed::fixed_max;
    end else begin
      dist_c = mag_c[value_width-1:0];
    end
    inlier_c = (dist_c <= threshold_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d              = state;
    plane_d              = plane_q;
    threshold_d          = threshold_q;
    num_points_d         = num_points_q;
    processed_d          = processed_q;
    inlier_count_d       = inlier_count;
    dot_d                = dot_q;
    dot_rhs_d            = dot_rhs_q;
    dot_start_d          = 1'b0;
    plane_ready_d        = plane_ready;
    point_ready_d        = point_ready;
    output_valid_d       = output_valid;
    point_result_valid_d = 1'b0;
    point_is_inlier_d    = point_is_inlier;
    case (state)
      IDLE: begin
        if (plane_valid && plane_ready) begin
          plane_d        = plane;
          threshold_d    = threshold;
          num_points_d   = num_points;
          processed_d    = '0;
          inlier_count_d = '0;
          plane_ready_d  = 1'b0;
          if (num_points == '0) begin
            state_d        = DONE;
            output_valid_d = 1'b1;
          end else begin
            state_d       = ACCEPT;
            point_ready_d = 1'b1;
          end
        end
      end
      ACCEPT: begin
        if (point_valid && point_ready) begin
          point_ready_d = 1'b0;
          dot_rhs_d     = point;
          dot_start_d   = 1'b1;
          state_d       = DOT_WAIT;
        end
      end
      DOT_WAIT: begin
        if (dot_valid) begin
          dot_d   = dot_result;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        point_result_valid_d = 1'b1;
        point_is_inlier_d    = inlier_c;
        if (inlier_c && (inlier_count != '1)) begin
          inlier_count_d = inlier_count + count_bits'(1);
        end
        processed_d = processed_q + count_bits'(1);
        if (processed_d == num_points_q) begin
          state_d        = DONE;
          output_valid_d = 1'b1;
        end else begin
          state_d       = ACCEPT;
          point_ready_d = 1'b1;
        end
      end
      DONE: begin
        if (output_ready) begin
          output_valid_d = 1'b0;
          plane_ready_d  = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state              <= IDLE;
      plane_q            <= '0;
      threshold_q        <= '0;
      num_points_q       <= '0;
      processed_q        <= '0;
      inlier_count       <= '0;
      dot_q              <= '0;
      dot_rhs_q          <= '0;
      dot_start_q        <= 1'b0;
      plane_ready        <= 1'b1;
      point_ready        <= 1'b0;
      output_valid       <= 1'b0;
      point_result_valid <= 1'b0;
      point_is_inlier    <= 1'b0;
    end else begin
      state              <= state_d;
      plane_q            <= plane_d;
      threshold_q        <= threshold_d;
      num_points_q       <= num_points_d;
      processed_q        <= processed_d;
      inlier_count       <= inlier_count_d;
      dot_q              <= dot_d;
      dot_rhs_q          <= dot_rhs_d;
      dot_start_q        <= dot_start_d;
      plane_ready        <= plane_ready_d;
      point_ready        <= point_ready_d;
      output_valid       <= output_valid_d;
      point_result_valid <= point_result_valid_d;
      point_is_inlier    <= point_is_inlier_d;
    end
  end
endmodule

// File: tb/tb_plane_inlier_counter.sv
// Scoreboard bench for plane_inlier_counter: per-point classifications and the final
// inlier count are queued when stimulus is issued and checked as the DUT reports them.

module tb_plane_inlier_counter;
  import ransac_fixed::*;

  localparam int budget = 200;
  localparam fixed_t one = 32'sd65536;

  logic clock;
  logic reset;
  plane_t plane;
  fixed_t threshold;
  logic [15:0] num_points;
  logic plane_valid, plane_ready;
  point_t point;
  logic point_valid, point_ready;
  logic point_result_valid, point_is_inlier;
  logic output_valid, output_ready;
  logic [15:0] inlier_count;

  int n_checks = 0;
  int n_fail = 0;

  bit exp_pt_q[$];
  logic [15:0] exp_cnt_q[$];
  point_t stim_pts[$];
  bit stim_exp[$];

  plane_inlier_counter dut (
    .clock              (clock),
    .reset              (reset),
    .plane              (plane),
    .threshold          (threshold),
    .num_points         (num_points),
    .plane_valid        (plane_valid),
    .plane_ready        (plane_ready),
    .point              (point),
    .point_valid        (point_valid),
    .point_ready        (point_ready),
    .point_result_valid (point_result_valid),
    .point_is_inlier    (point_is_inlier),
    .output_valid       (output_valid),
    .output_ready       (output_ready),
    .inlier_count       (inlier_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference classification: floor-shifted dot, saturating distance, inclusive threshold.
  function automatic bit model_inlier(input plane_t p, input fixed_t thr, input point_t q);
    longint s, diff;
    s = longint'(p.normal.x) * longint'(q.x) + longint'(p.normal.y) * longint'(q.y)
      + longint'(p.normal.z) * longint'(q.z);
    s = s >>> 16;
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    diff = s - longint'(p.d);
    if (diff < 0) diff = -diff;
    if (diff > 64'sd2147483647) diff = 64'sd2147483647;
    return diff <= longint'(thr);
  endfunction

  function automatic point_t mkpt(input fixed_t x, input fixed_t y, input fixed_t z);
    point_t p;
    p.x = x; p.y = y; p.z = z;
    return p;
  endfunction

  function automatic plane_t mkplane(input fixed_t nx, input fixed_t ny, input fixed_t nz, input fixed_t d);
    plane_t p;
    p.normal = mkpt(nx, ny, nz);
    p.d = d;
    return p;
  endfunction

  task automatic add(input point_t p, input bit e);
    stim_pts.push_back(p);
    stim_exp.push_back(e);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (point_result_valid) begin
        check_eq("pt_queue_nonempty", 64'(exp_pt_q.size() > 0), 1);
        if (exp_pt_q.size() > 0) check_eq("pt_inlier", point_is_inlier, exp_pt_q.pop_front());
      end
      if (output_valid && output_ready) begin
        check_eq("cnt_queue_nonempty", 64'(exp_cnt_q.size() > 0), 1);
        if (exp_cnt_q.size() > 0) check_eq("inlier_count", inlier_count, exp_cnt_q.pop_front());
      end
    end
  end

  task automatic drive_plane(input plane_t p, input fixed_t thr, input logic [15:0] n);
    bit taken = 0;
    plane = p; threshold = thr; num_points = n; plane_valid = 1'b1;
    for (int i = 0; i < budget && !taken; i++) begin
      taken = plane_ready;
      @(posedge clock); #1;
    end
    plane_valid = 1'b0;
    plane = plane_t'({$urandom, $urandom, $urandom, $urandom});
    threshold = fixed_t'($urandom);
    num_points = 16'($urandom);
    check_eq("plane_accept", 64'(taken), 1);
  endtask

  task automatic send_point(input point_t q);
    bit taken = 0;
    point = q; point_valid = 1'b1;
    for (int i = 0; i < budget && !taken; i++) begin
      taken = point_ready;
      @(posedge clock); #1;
    end
    point_valid = 1'b0;
    point = point_t'({$urandom, $urandom, $urandom});
    check_eq("point_accept", 64'(taken), 1);
  endtask

  task automatic wait_output(input logic [15:0] exp, input int hold);
    for (int i = 0; i < budget && !output_valid; i++) begin
      @(posedge clock); #1;
    end
    check_eq("out_valid", output_valid, 1);
    for (int i = 0; i < hold; i++) begin
      plane_valid = 1'b1;
      plane = plane_t'({$urandom, $urandom, $urandom, $urandom});
      num_points = 16'd1;
      @(posedge clock); #1;
      check_eq("stall_valid", output_valid, 1);
      check_eq("stall_count", inlier_count, exp);
      check_eq("stall_plane_ready", plane_ready, 0);
    end
    plane_valid = 1'b0;
    output_ready = 1'b1;
    @(posedge clock); #1;
    output_ready = 1'b0;
    check_eq("post_out_valid", output_valid, 0);
    check_eq("post_plane_ready", plane_ready, 1);
  endtask

  task automatic run_hyp(input plane_t p, input fixed_t thr, input int hold, input bit gaps);
    int cnt = 0;
    int n = stim_pts.size();
    foreach (stim_exp[i]) begin
      exp_pt_q.push_back(stim_exp[i]);
      cnt += int'(stim_exp[i]);
    end
    exp_cnt_q.push_back(16'(cnt));
    drive_plane(p, thr, 16'(n));
    if (n == 0) begin
      check_eq("zero_out_valid", output_valid, 1);
      check_eq("zero_point_ready", point_ready, 0);
    end
    foreach (stim_pts[i]) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
      send_point(stim_pts[i]);
    end
    wait_output(16'(cnt), hold);
    stim_pts.delete();
    stim_exp.delete();
  endtask

  initial begin
    plane_t pl;
    fixed_t thr;
    reset = 1'b0;
    plane = '0; threshold = '0; num_points = '0; plane_valid = 1'b0;
    point = '0; point_valid = 1'b0; output_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_plane_ready", plane_ready, 1);
    check_eq("rst_point_ready", point_ready, 0);
    check_eq("rst_output_valid", output_valid, 0);
    check_eq("rst_result_valid", point_result_valid, 0);
    check_eq("rst_inlier_count", inlier_count, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Basic classification around z = 2.0.
    pl = mkplane(0, 0, one, 2 * one);
    add(mkpt(fixed_t'($urandom), fixed_t'($urandom), 32'sd131072), 1'b1);
    add(mkpt(fixed_t'($urandom), fixed_t'($urandom), 32'sd134349), 1'b1);
    add(mkpt(fixed_t'($urandom), fixed_t'($urandom), 32'sd196608), 1'b0);
    add(mkpt(fixed_t'($urandom), fixed_t'($urandom), -32'sd131072), 1'b0);
    run_hyp(pl, 32'sd6554, 3, 1'b0);

    // Threshold boundary: equal distance is an inlier, one LSB more is not.
    add(mkpt(0, 0, 32'sd163840), 1'b1);
    add(mkpt(0, 0, 32'sd163841), 1'b0);
    run_hyp(pl, 32'sd32768, 0, 1'b0);

    // Zero points.
    run_hyp(pl, 32'sd32768, 0, 1'b0);

    // Random valid gaps and a long output stall.
    pl = mkplane(fixed_t'(int'($urandom_range(0, 131072)) - 65536),
                 fixed_t'(int'($urandom_range(0, 131072)) - 65536),
                 fixed_t'(int'($urandom_range(0, 131072)) - 65536),
                 fixed_t'(int'($urandom_range(0, 65536)) - 32768));
    thr = fixed_t'($urandom_range(0, 1 << 19));
    for (int i = 0; i < 8; i++) begin
      point_t q;
      q = mkpt(fixed_t'(int'($urandom_range(0, 1 << 21)) - (1 << 20)),
               fixed_t'(int'($urandom_range(0, 1 << 21)) - (1 << 20)),
               fixed_t'(int'($urandom_range(0, 1 << 21)) - (1 << 20)));
      add(q, model_inlier(pl, thr, q));
    end
    run_hyp(pl, thr, 10, 1'b1);

    // Extreme distances saturate instead of wrapping.
    pl = mkplane(one, 0, 0, fixed_min);
    add(mkpt(fixed_max, 0, 0), 1'b1);
    run_hyp(pl, fixed_max, 0, 1'b0);
    add(mkpt(fixed_max, 0, 0), 1'b0);
    add(mkpt(-32'sd2, 0, 0), 1'b1);
    run_hyp(pl, fixed_max - 32'sd1, 0, 1'b0);

    // Reset while the dot product is in flight.
    pl = mkplane(0, 0, one, 2 * one);
    drive_plane(pl, 32'sd6554, 16'd1);
    send_point(mkpt(0, 0, 32'sd131072));
    reset = 1'b0;
    @(posedge clock); #1;
    check_eq("abort_plane_ready", plane_ready, 1);
    check_eq("abort_output_valid", output_valid, 0);
    check_eq("abort_point_ready", point_ready, 0);
    check_eq("abort_inlier_count", inlier_count, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    add(mkpt(0, 0, 32'sd131072), 1'b1);
    add(mkpt(0, 0, 32'sd196608), 1'b0);
    add(mkpt(0, 0, 32'sd128000), 1'b1);
    run_hyp(pl, 32'sd6554, 0, 1'b0);

    repeat (5) @(posedge clock);
    #1;
    check_eq("pt_queue_drained", 64'(exp_pt_q.size()), 0);
    check_eq("cnt_queue_drained", 64'(exp_cnt_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected completion within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
